pool_array_dp: RTL and testbench

POOL_ARRAY_DP -- requirements
Module: pool_array_dp

---
 rtl/pool_array_dp_if.sv | 35 +++
 rtl/pool_array_dp.sv | 120 ++++++++++++
 tb/tb_pool_array_dp.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pool_array_dp_if.sv
// Streaming port bundle for pool_array_dp: frame control, pixel input
// beat and pooled output beat. The driver side uses master, the pooling
// datapath uses slave.
interface pool_array_dp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_UNITS  = 3
);
    logic                            clear;
    logic                            avg_mode;
    logic                            in_valid;
    logic [NUM_UNITS*DATA_WIDTH-1:0] in_data;
    logic                            out_valid;
    logic [NUM_UNITS*DATA_WIDTH-1:0] out_data;
    logic                            frame_done;

    modport master (
        output clear,
        output avg_mode,
        output in_valid,
        output in_data,
        input  out_valid,
        input  out_data,
        input  frame_done
    );

    modport slave (
        input  clear,
        input  avg_mode,
        input  in_valid,
        input  in_data,
        output out_valid,
        output out_data,
        output frame_done
    );
endinterface

// File: rtl/pool_array_dp.sv
// pool_array_dp: 2x2 / stride-2 max or average pooling over NUM_UNITS
// independent channels of a square raster-order feature map.
// Each even-row pixel pair is reduced to a partial (max or sum) and parked
// in a per-channel line buffer; the matching odd-row pair completes the
// window and the result is registered one cycle later.
module pool_array_dp #(
    parameter int DATA_WIDTH = 32,
    parameter int IFM_SIZE   = 14,
    parameter int NUM_UNITS  = 3,
    localparam int OFM_SIZE  = IFM_SIZE / 2
) (
    input logic            clk,
    input logic            reset,
    pool_array_dp_if.slave bus
);
    // Two guard bits keep a 4-pixel sum from ever overflowing.
    localparam int SUM_W = DATA_WIDTH + 2;
    localparam int CNT_W = $clog2(IFM_SIZE);
    localparam int LB_W  = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IFM_SIZE - 1);

    logic [CNT_W-1:0]                col_cnt;
    logic [CNT_W-1:0]                row_cnt;
    logic [LB_W-1:0]                 col_half;
    logic                            beat;
    logic                            pair_beat;
    logic                            win_beat;
    logic                            last_beat;
    logic                            col_last;
    logic                            out_valid_q;
    logic                            frame_done_q;
    logic [NUM_UNITS*DATA_WIDTH-1:0] out_data_q;
    logic [NUM_UNITS*DATA_WIDTH-1:0] win_res;

    // Classify the current beat by raster position; clear drops the pixel.
    // With odd IFM_SIZE the last row/column are even-indexed, so they can
    // never complete a window and need no extra guard.
    always_comb begin
        beat      = bus.in_valid && !bus.clear;
        col_last  = (col_cnt == LAST_IDX);
        pair_beat = beat && col_cnt[0] && !row_cnt[0];
        win_beat  = beat && col_cnt[0] && row_cnt[0];
        last_beat = beat && col_last && (row_cnt == LAST_IDX);
        col_half  = LB_W'(col_cnt >> 1);
    end

    // Raster counters plus the registered output beat and frame marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_cnt      <= '0;
            row_cnt      <= '0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            out_data_q   <= '0;
        end else begin
            out_valid_q  <= win_beat;
            frame_done_q <= last_beat;
            if (win_beat) begin
                out_data_q <= win_res;
            end
            if (bus.clear) begin
                col_cnt <= '0;
                row_cnt <= '0;
            end else if (bus.in_valid) begin
                if (col_last) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_UNITS; k++) begin : g_ch
        logic signed [DATA_WIDTH-1:0] px;
        logic signed [DATA_WIDTH-1:0] prev_px;
        logic signed [DATA_WIDTH-1:0] pair_max;
        logic signed [DATA_WIDTH-1:0] stored_max;
        logic signed [DATA_WIDTH-1:0] quad_max;
        logic signed [DATA_WIDTH-1:0] avg_res;
        logic signed [SUM_W-1:0]      pair_sum;
        logic signed [SUM_W-1:0]      partial;
        logic signed [SUM_W-1:0]      stored;
        logic signed [SUM_W-1:0]      quad_sum;
        logic signed [SUM_W-1:0]      lbuf [OFM_SIZE];

        // Reduce the current horizontal pair, then fold in the parked
        // partial from the row above. The partial holds either a
        // sign-extended max or a pair sum depending on the mode at write.
        always_comb begin
            px         = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
            pair_max   = (px > prev_px) ? px : prev_px;
            pair_sum   = {{2{px[DATA_WIDTH-1]}}, px} + {{2{prev_px[DATA_WIDTH-1]}}, prev_px};
            partial    = bus.avg_mode ? pair_sum : {{2{pair_max[DATA_WIDTH-1]}}, pair_max};
            stored     = lbuf[col_half];
            stored_max = DATA_WIDTH'(stored);
            quad_max   = (stored_max > pair_max) ? stored_max : pair_max;
            quad_sum   = stored + pair_sum;
            avg_res    = DATA_WIDTH'(quad_sum >>> 2);
        end

        // Pixel history and line buffer carry no reset: after any restart
        // column 0 and row 0 are always rewritten before they are read.
        always_ff @(posedge clk) begin
            if (beat) begin
                prev_px <= px;
            end
            if (pair_beat) begin
                lbuf[col_half] <= partial;
            end
        end

        assign win_res[k*DATA_WIDTH +: DATA_WIDTH] = bus.avg_mode ? avg_res : quad_max;
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_array_dp.sv
// Bench for pool_array_dp: an IFM_SIZE=4 instance driven from a table of
// known frames and corner sequences, and an IFM_SIZE=5 instance driven
// with random back-to-back frames against a frame-image model.
module tb_pool_array_dp;
    localparam int DW = 8;
    localparam int NU = 2;

    typedef struct { int cyc; int d0; int d1; } exp_t;
    typedef struct { logic md; int gap; int kind; int e0[4]; int e1[4]; } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;

    exp_t          q_out[2][$];
    int            q_done[2][$];
    logic [2*DW-1:0] last_exp[2];
    int            img[2][2][5][5];
    int            mrow[2];
    int            mcol[2];
    bit            tbl_mode;
    int            tbl_k;
    int            tbl_e0[4];
    int            tbl_e1[4];
    vec_t          vt[6];

    pool_array_dp_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU)) bus_a ();
    pool_array_dp_if #(.DATA_WIDTH(DW), .NUM_UNITS(NU)) bus_b ();

    pool_array_dp #(.DATA_WIDTH(DW), .IFM_SIZE(4), .NUM_UNITS(NU)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a.slave));
    pool_array_dp #(.DATA_WIDTH(DW), .IFM_SIZE(5), .NUM_UNITS(NU)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rnd();
        return int'($urandom_range(255)) - 128;
    endfunction

    function automatic int tpix(int kind, int b, int c);
        if (kind == 0) return (c == 0) ? b : -b;
        if (kind == 1) return (c == 0) ? 127 : -128;
        return (c == 0) ? -128 : 127;
    endfunction

    // Expected window result from the stored frame image at the model position.
    function automatic int pool(int d, int c, logic md);
        int r = mrow[d];
        int q = mcol[d];
        int a = img[d][c][r-1][q-1];
        int b = img[d][c][r-1][q];
        int e = img[d][c][r][q-1];
        int f = img[d][c][r][q];
        int m;
        if (md) return (a + b + e + f) >>> 2;
        m = a;
        if (b > m) m = b;
        if (e > m) m = e;
        if (f > m) m = f;
        return m;
    endfunction

    task automatic add_vec(int i, logic md, int gap, int kind,
                           int a0, int a1, int a2, int a3,
                           int b0, int b1, int b2, int b3);
        vt[i].md = md; vt[i].gap = gap; vt[i].kind = kind;
        vt[i].e0 = '{a0, a1, a2, a3};
        vt[i].e1 = '{b0, b1, b2, b3};
    endtask

    task automatic chk(string name, logic [15:0] got, logic [15:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // One clock of stimulus on DUT d; updates the model and pushes expectations.
    task automatic step(int d, logic v, logic clr, logic md, int p0, int p1);
        int s;
        exp_t e;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0; bus_a.clear = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.clear = 1'b0;
        if (d == 0) begin
            bus_a.in_valid = v; bus_a.clear = clr; bus_a.avg_mode = md;
            bus_a.in_data = {8'(p1), 8'(p0)};
        end else begin
            bus_b.in_valid = v; bus_b.clear = clr; bus_b.avg_mode = md;
            bus_b.in_data = {8'(p1), 8'(p0)};
        end
        s = (d == 0) ? 4 : 5;
        if (clr) begin
            mrow[d] = 0;
            mcol[d] = 0;
        end else if (v) begin
            img[d][0][mrow[d]][mcol[d]] = p0;
            img[d][1][mrow[d]][mcol[d]] = p1;
            if ((mrow[d] % 2 == 1) && (mcol[d] % 2 == 1)) begin
                e.cyc = cyc + 1;
                if (tbl_mode && d == 0 && tbl_k < 4) begin
                    e.d0 = tbl_e0[tbl_k];
                    e.d1 = tbl_e1[tbl_k];
                    tbl_k++;
                end else begin
                    e.d0 = pool(d, 0, md);
                    e.d1 = pool(d, 1, md);
                end
                q_out[d].push_back(e);
            end
            if (mrow[d] == s - 1 && mcol[d] == s - 1) q_done[d].push_back(cyc + 1);
            if (mcol[d] == s - 1) begin
                mcol[d] = 0;
                mrow[d] = (mrow[d] == s - 1) ? 0 : mrow[d] + 1;
            end else begin
                mcol[d] = mcol[d] + 1;
            end
        end
    endtask

    task automatic flush();
        for (int d = 0; d < 2; d++) begin
            q_out[d].delete();
            q_done[d].delete();
            mrow[d] = 0;
            mcol[d] = 0;
            last_exp[d] = '0;
        end
    endtask

    task automatic mon(int d, logic v, logic [15:0] dat, logic fd);
        exp_t e;
        logic signed [7:0] g0, g1;
        while (q_out[d].size() > 0 && q_out[d][0].cyc < cyc) begin
            n_vec++; n_miss++;
            $display("FAIL dut%0d missing_out_valid cyc=%0d got 0 want 1", d, q_out[d][0].cyc);
            void'(q_out[d].pop_front());
        end
        while (q_done[d].size() > 0 && q_done[d][0] < cyc) begin
            n_vec++; n_miss++;
            $display("FAIL dut%0d missing_frame_done cyc=%0d got 0 want 1", d, q_done[d][0]);
            void'(q_done[d].pop_front());
        end
        n_vec++;
        if (v === 1'b1) begin
            if (q_out[d].size() == 0 || q_out[d][0].cyc != cyc) begin
                n_miss++;
                $display("FAIL dut%0d spurious_out_valid cyc=%0d got 1 want 0", d, cyc);
            end else begin
                e = q_out[d].pop_front();
                g0 = dat[7:0];
                g1 = dat[15:8];
                if (int'(g0) != e.d0 || int'(g1) != e.d1) begin
                    n_miss++;
                    $display("FAIL dut%0d out_data cyc=%0d got ch0=%0d ch1=%0d want ch0=%0d ch1=%0d",
                             d, cyc, g0, g1, e.d0, e.d1);
                end
                last_exp[d] = {8'(e.d1), 8'(e.d0)};
            end
        end else if (dat !== last_exp[d]) begin
            n_miss++;
            $display("FAIL dut%0d out_data_hold cyc=%0d got=%0h want=%0h", d, cyc, dat, last_exp[d]);
        end
        if (fd === 1'b1) begin
            n_vec++;
            if (q_done[d].size() > 0 && q_done[d][0] == cyc) begin
                void'(q_done[d].pop_front());
            end else begin
                n_miss++;
                $display("FAIL dut%0d spurious_frame_done cyc=%0d got 1 want 0", d, cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            mon(0, bus_a.out_valid, bus_a.out_data, bus_a.frame_done);
            mon(1, bus_b.out_valid, bus_b.out_data, bus_b.frame_done);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        add_vec(0, 1'b0, 0, 0, 5, 7, 13, 15, 0, -2, -8, -10);
        add_vec(1, 1'b1, 0, 0, 2, 4, 10, 12, -3, -5, -11, -13);
        add_vec(2, 1'b1, 0, 1, 127, 127, 127, 127, -128, -128, -128, -128);
        add_vec(3, 1'b1, 0, 2, -128, -128, -128, -128, 127, 127, 127, 127);
        add_vec(4, 1'b0, 2, 0, 5, 7, 13, 15, 0, -2, -8, -10);
        add_vec(5, 1'b0, 0, 1, 127, 127, 127, 127, -128, -128, -128, -128);

        reset = 1'b1;
        tbl_mode = 1'b0;
        tbl_k = 0;
        bus_a.clear = 0; bus_a.avg_mode = 0; bus_a.in_valid = 0; bus_a.in_data = '0;
        bus_b.clear = 0; bus_b.avg_mode = 0; bus_b.in_valid = 0; bus_b.in_data = '0;
        flush();
        #2;
        chk("a_reset_out_valid", 16'(bus_a.out_valid), 16'h0);
        chk("a_reset_out_data", bus_a.out_data, 16'h0);
        chk("a_reset_frame_done", 16'(bus_a.frame_done), 16'h0);
        chk("b_reset_out_valid", 16'(bus_b.out_valid), 16'h0);
        chk("b_reset_out_data", bus_b.out_data, 16'h0);
        chk("b_reset_frame_done", 16'(bus_b.frame_done), 16'h0);
        @(posedge clk);
        @(posedge clk);
        #3 reset = 1'b0;

        // Table frames on the 4x4 instance, back to back.
        tbl_mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tbl_k = 0;
            tbl_e0 = vt[i].e0;
            tbl_e1 = vt[i].e1;
            for (int b = 0; b < 16; b++) begin
                step(0, 1'b1, 1'b0, vt[i].md, tpix(vt[i].kind, b, 0), tpix(vt[i].kind, b, 1));
                for (int g = 0; g < vt[i].gap; g++) step(0, 1'b0, 1'b0, vt[i].md, 0, 0);
            end
        end
        tbl_mode = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Odd-size map: two back-to-back random frames, max then avg.
        for (int f = 0; f < 2; f++)
            for (int b = 0; b < 25; b++) step(1, 1'b1, 1'b0, (f == 1), rnd(), rnd());
        for (int i = 0; i < 3; i++) step(1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Clear after beat 6 drops the pixel and restarts at (0,0).
        for (int b = 0; b < 6; b++) step(0, 1'b1, 1'b0, 1'b0, rnd(), rnd());
        step(0, 1'b1, 1'b1, 1'b0, rnd(), rnd());
        for (int b = 0; b < 16; b++) step(0, 1'b1, 1'b0, 1'b0, rnd(), rnd());
        // Clear landing on a window-completing beat suppresses that output.
        for (int b = 0; b < 5; b++) step(0, 1'b1, 1'b0, 1'b1, rnd(), rnd());
        step(0, 1'b1, 1'b1, 1'b1, rnd(), rnd());
        for (int b = 0; b < 16; b++) step(0, 1'b1, 1'b0, 1'b1, rnd(), rnd());
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b0, 0, 0);

        // Reset mid-frame while an output is being presented.
        for (int b = 0; b < 6; b++) step(0, 1'b1, 1'b0, 1'b0, tpix(0, b, 0), tpix(0, b, 1));
        @(posedge clk);
        #2;
        bus_a.in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 16'(bus_a.out_valid), 16'h0);
        chk("midrst_out_data", bus_a.out_data, 16'h0);
        chk("midrst_frame_done", 16'(bus_a.frame_done), 16'h0);
        flush();
        @(posedge clk);
        #3 reset = 1'b0;
        for (int b = 0; b < 16; b++) step(0, 1'b1, 1'b0, 1'b0, rnd(), rnd());
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b0, 1'b0, 0, 0);

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_leftover_out", d), 16'(q_out[d].size()), 16'h0);
            chk($sformatf("dut%0d_leftover_done", d), 16'(q_done[d].size()), 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
